// File: rtl/wb_arb_pkg.sv
// Shared types for the regfile write arbiter: source-select enum, exception
// register index and the queued mult/div result entry layout.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_FIFO,
    SRC_MD_DIRECT
  } wb_src_e;

  localparam int EXC_REG   = 30;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding deferred mult/div results. The head is visible
// combinationally so it can be popped in the same cycle; a full FIFO refuses pushes
// even when a pop happens in that cycle.
module wb_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writeback, exception status writes and queued mult/div results onto
// the single regfile write port. Optional WB_ARB_PERF_CNT_EN adds defer/stall counters.
module regfile_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int EXC_REG      = wb_arb_pkg::EXC_REG
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exc_valid,
  input  logic [DATA_W-1:0] exc_code,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              stall_pipe,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
`ifdef WB_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_defer_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  import wb_arb_pkg::*;

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int SW      = $clog2(STARVE_LIMIT + 1);

  wb_src_e           src;
  logic              pop, push, accept, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0] head_rd, wr_idx;
  logic [DATA_W-1:0] head_data, wr_data;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;

  wb_result_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .push       (push),
    .pop        (pop),
    .wdata      ({md_rd, md_data}),
    .rdata      (fifo_head),
    .count      (fifo_count)
  );

  assign head_rd    = fifo_head[ENTRY_W-1 -: ADDR_W];
  assign head_data  = fifo_head[DATA_W-1:0];
  assign fifo_empty = (fifo_count == '0);
  assign md_ready   = (fifo_count < CW'(FIFO_DEPTH));

  always_comb begin
    src     = SRC_NONE;
    pop     = 1'b0;
    wr_idx  = wb_rd;
    wr_data = wb_data;
    if (stall_q && !fifo_empty) begin
      src     = SRC_FIFO;
      pop     = 1'b1;
      wr_idx  = head_rd;
      wr_data = head_data;
    end else if (wb_valid) begin
      src = SRC_PIPE;
      if (exc_valid) begin
        wr_idx  = ADDR_W'(EXC_REG);
        wr_data = exc_code;
      end
    end else if (!fifo_empty) begin
      src     = SRC_FIFO;
      pop     = 1'b1;
      wr_idx  = head_rd;
      wr_data = head_data;
    end else if (md_valid) begin
      src     = SRC_MD_DIRECT;
      wr_idx  = md_rd;
      wr_data = md_data;
    end
    accept = md_valid && md_ready;
    push   = accept && (src != SRC_MD_DIRECT);
  end

  // Register 0 writes are swallowed; the write index/data hold the last real write.
  always_comb begin
    we_d    = (src != SRC_NONE) && (wr_idx != '0);
    wreg_d  = we_d ? wr_idx : wreg_q;
    wdata_d = we_d ? wr_data : wdata_q;
    starve_d = starve_q;
    stall_d  = stall_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else begin
      if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
      if (starve_q >= SW'(STARVE_LIMIT)) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign stall_pipe       = stall_q;

`ifdef WB_ARB_PERF_CNT_EN
  logic [31:0] defer_cnt_q, defer_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    defer_cnt_d = defer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!fifo_empty && !pop && (defer_cnt_q != '1)) defer_cnt_d = defer_cnt_q + 1'b1;
    if (stall_q) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      defer_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      defer_cnt_q <= defer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_defer_cnt = defer_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Writeback-side stage directly upstream of the register file; sole driver of ctrl_writeEnable, ctrl_writeReg and data_writeReg.
- Merges three sources onto the single regfile write port:
  - in-order pipeline writeback from the M/W latch;
  - exception status writes, which redirect to $rstatus;
  - out-of-order results from the multi-cycle mult/div unit, held in a small FIFO.
- Guarantees forward progress of queued mult/div results by back-pressuring the pipeline when a result starves.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- FIFO_DEPTH, 2, mult/div result queue entries (power of 2, >=2)
- STARVE_LIMIT, 4, consecutive deferred cycles before pipeline stall is requested
- EXC_REG, 30, register index that receives exception codes

Ports:
- clock  in  1  system clock, rising edge
- ctrl_reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  pipeline writeback valid this cycle
- wb_rd  in  ADDR_W  pipeline destination register
- wb_data  in  DATA_W  pipeline writeback data
- exc_valid  in  1  qualifies wb_valid; redirects the write to EXC_REG
- exc_code  in  DATA_W  exception status value
- md_valid  in  1  mult/div result offered
- md_rd  in  ADDR_W  mult/div destination register
- md_data  in  DATA_W  mult/div result
- md_ready  out  1  arbiter accepts md result this cycle
- stall_pipe  out  1  pipeline must hold W stage (drive wb_valid=0)
- ctrl_writeEnable  out  1  regfile write enable
- ctrl_writeReg  out  ADDR_W  regfile write index
- data_writeReg  out  DATA_W  regfile write data

Behaviour:
- Reset (ctrl_reset=0, async):
  - FIFO empty; starve counter 0.
  - Outputs: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, stall_pipe=0, md_ready=1.
  - Reset asserted mid-operation discards queued results without writing them.
- Outputs to the regfile are registered. Latency is 1 cycle from the winning source to ctrl_writeEnable, so the regfile commits on the following edge.
- Winner selection each cycle, in priority order:
  - (a) stall_pipe=1 and FIFO non-empty: FIFO head wins.
  - (b) else wb_valid=1: pipeline wins. Index is EXC_REG if exc_valid=1, else wb_rd. Data is exc_code if exc_valid=1, else wb_data. exc_valid while wb_valid=0 is ignored.
  - (c) else FIFO non-empty: head is popped and wins.
  - (d) else md_valid=1 with FIFO empty: direct pass-through. md is accepted and written without being enqueued.
  - (e) else idle: ctrl_writeEnable=0, ctrl_writeReg and data_writeReg hold their last values.
- Register 0: if the winning index is 0, ctrl_writeEnable=0. The entry is still consumed (popped or accepted).
- md handshake:
  - Transfer occurs when md_valid && md_ready.
  - md_ready = (FIFO count < FIFO_DEPTH), derived from registered count only.
  - No push-through when full: a pop in the same cycle does not raise md_ready.
  - Accepted md not taking the direct path (d) is pushed to the tail.
  - Simultaneous push and pop: count unchanged, ordering preserved.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped; clears on pop or when the FIFO is empty.
  - stall_pipe is registered: asserted the cycle after counter reaches STARVE_LIMIT; deasserted the cycle after the head pop.
- Protocol violation: wb_valid=1 while stall_pipe=1 means the wb write is lost. The bench flags this with an assertion.
- Ordering: FIFO is strictly FIFO. WAW between mult/div and pipeline results is the pipeline's hazard logic's responsibility, not this block's.

Optional Feature:
- Macro: WB_ARB_PERF_CNT_EN.
- Defined:
  - Adds output perf_defer_cnt [31:0], a saturating count of cycles with FIFO non-empty and no pop.
  - Adds output perf_stall_cnt [31:0], counting cycles with stall_pipe=1.
  - Both reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package wb_arb_pkg holds:
  - source-select enum: SRC_NONE, SRC_PIPE, SRC_FIFO, SRC_MD_DIRECT;
  - localparam EXC_REG default 30;
  - result entry typedef {rd[ADDR_W], data[DATA_W]}.
- One sub-module, wb_result_fifo: parameterised sync FIFO with count output, push/pop, no push-through.
- Arbitration, starve counter and output registers live in the top module.

Test Plan:
- Reset: hold ctrl_reset=0 with md_valid=1 -> ctrl_writeEnable=0, md_ready=1, stall_pipe=0; release -> first write one cycle after first winner.
- Pipeline only: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; same with wb_rd=0 -> ctrl_writeEnable=0.
- Exception redirect: wb_valid=1, exc_valid=1, wb_rd=7, exc_code=2 -> ctrl_writeReg=30, data_writeReg=2.
- Direct mult/div: FIFO empty, wb_valid=0, md_valid=1, md_rd=9, md_data=42 -> md_ready=1, next cycle writes r9=42, FIFO count stays 0.
- Fill and back-pressure: wb_valid=1 continuously, push md results rd=3 then rd=4 -> md_ready=0 after 2 pushes. Four cycles later stall_pipe=1. Bench drops wb_valid -> r3 then r4 written in order, stall_pipe clears the cycle after the rd=3 pop.
- Simultaneous push/pop: FIFO count 1, wb_valid=0, md_valid=1 -> head written, new entry queued, count remains 1, md_ready=1.
